// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared types and helpers for the parametrised N-requester arbiter.
//   arb_mode_e    : arbitration policy (round-robin / fixed priority)
//   arb_state_e   : arbiter FSM state
//   onehot_to_idx : one-hot vector (up to ARB_MAX_REQ bits) to binary index
// -----------------------------------------------------------------------------
package arb_pkg;

  typedef enum logic {ARB_RR = 1'b0, ARB_FIXED = 1'b1} arb_mode_e;
  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} arb_state_e;

  // Upper bound on requesters supported by the index helper.
  localparam int ARB_MAX_REQ = 32;
  localparam int ARB_IDX_W   = 5;

  // OR-reduction encoder: for a true one-hot input every set bit contributes
  // its own index, so no priority chain is needed. Zero input gives zero.
  function automatic logic [ARB_IDX_W-1:0] onehot_to_idx(input logic [ARB_MAX_REQ-1:0] oh);
    logic [ARB_IDX_W-1:0] idx;
    idx = {ARB_IDX_W{1'b0}};
    for (int i = 0; i < ARB_MAX_REQ; i++) begin
      idx = idx | ({ARB_IDX_W{oh[i]}} & i[ARB_IDX_W-1:0]);
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// -----------------------------------------------------------------------------
// arb_pick
// Combinational winner picker. Eligible requests (req & mask) are rotated so
// that the search start sits at bit 0, the lowest set bit is isolated, and the
// result is rotated back. Fixed-priority mode forces the start to index 0.
// Ports:
//   req    in  N_REQ  request levels
//   mask   in  N_REQ  per-requester eligibility (0 excludes a requester)
//   start  in  ID_W   first index searched in round-robin mode (< N_REQ)
//   mode   in  1      ARB_RR / ARB_FIXED
//   winner out N_REQ  one-hot winner, zero when nothing eligible
//   found  out 1      at least one eligible request
// -----------------------------------------------------------------------------
module arb_pick
  import arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mask,
  input  logic [ID_W-1:0]  start,
  input  arb_mode_e        mode,
  output logic [N_REQ-1:0] winner,
  output logic             found
);

  logic [N_REQ-1:0] elig_s;
  logic [ID_W-1:0]  start_s;
  logic [N_REQ-1:0] rot_s;
  logic [N_REQ-1:0] rot_oh_s;

  // Rotate, isolate lowest set bit, rotate back.
  always_comb begin
    elig_s   = req & mask;
    if (mode == ARB_FIXED) begin
      start_s = {ID_W{1'b0}};
    end else begin
      start_s = start;
    end
    // Right-rotate by start: rot_s[i] = elig_s[(i+start) mod N_REQ].
    rot_s    = N_REQ'({elig_s, elig_s} >> start_s);
    // x & -x keeps only the lowest set bit.
    rot_oh_s = rot_s & (~rot_s + {{(N_REQ-1){1'b0}}, 1'b1});
    // Left-rotate back by start, taking the upper copy.
    winner   = N_REQ'(({rot_oh_s, rot_oh_s} << start_s) >> N_REQ);
    found    = |elig_s;
  end

endmodule

// File: rtl/arb_rr_param_chk.sv
// -----------------------------------------------------------------------------
// arb_rr_param_chk
// Protocol checker for arb_rr_param; observes the arbiter ports only.
// Ports: clk, rst, request, grant, grant_valid, grant_id (all inputs).
// All properties are disabled while rst is high.
// -----------------------------------------------------------------------------
module arb_rr_param_chk #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input logic             clk,
  input logic             rst,
  input logic [N_REQ-1:0] request,
  input logic [N_REQ-1:0] grant,
  input logic             grant_valid,
  input logic [ID_W-1:0]  grant_id
);

  a_req_known: assert property (@(posedge clk) disable iff (rst)
    !$isunknown(request));

  a_grant_onehot0: assert property (@(posedge clk) disable iff (rst)
    $onehot0(grant));

  a_valid_match: assert property (@(posedge clk) disable iff (rst)
    grant_valid == (|grant));

  a_id_match: assert property (@(posedge clk) disable iff (rst)
    (grant == {N_REQ{1'b0}}) ? (grant_id == {ID_W{1'b0}}) : grant[grant_id]);

  // The grant seen now was decided at the previous edge from the request
  // sampled there.
  a_grant_requested: assert property (@(posedge clk) disable iff (rst)
    (|grant) |-> (|(grant & $past(request))));

endmodule

// File: rtl/arb_rr_param.sv
// -----------------------------------------------------------------------------
// arb_rr_param
// Parametrised N-requester arbiter, round-robin or fixed priority, with a
// bounded grant hold. Outputs are registered; rst clears them asynchronously.
// Ports:
//   clk          in  1      system clock (posedge)
//   rst          in  1      asynchronous active-high reset
//   mode         in  1      0 = round-robin, 1 = fixed priority (0 highest)
//   request      in  N_REQ  request levels
//   grant        out N_REQ  one-hot grant, zero when idle
//   grant_valid  out 1      |grant
//   grant_id     out ID_W   index of the owner, zero when idle
// N_REQ must not exceed arb_pkg::ARB_MAX_REQ.
// -----------------------------------------------------------------------------
module arb_rr_param
  import arb_pkg::*;
#(
  parameter  int N_REQ    = 4,
  parameter  int MAX_HOLD = 8,
  localparam int ID_W     = $clog2(N_REQ),
  localparam int CNT_W    = $clog2(MAX_HOLD + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic [N_REQ-1:0] request,
  output logic [N_REQ-1:0] grant,
  output logic             grant_valid,
  output logic [ID_W-1:0]  grant_id
);

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD - 1);
  localparam logic [ID_W-1:0]  LAST_IDX = ID_W'(N_REQ - 1);

  arb_state_e       state_r, state_n_s;
  logic [N_REQ-1:0] grant_r, grant_n_s;
  logic             grant_valid_r;
  logic [ID_W-1:0]  grant_id_r, grant_id_n_s;
  logic [CNT_W-1:0] hold_cnt_r, hold_cnt_n_s;
  logic [ID_W-1:0]  rr_last_r, rr_last_n_s;

  logic             own_req_s;
  logic             others_s;
  logic [N_REQ-1:0] mask_s;
  logic [ID_W-1:0]  rr_start_s;
  logic [N_REQ-1:0] win_s;
  logic             found_s;
  logic [ID_W-1:0]  win_id_s;
  logic             take_s;
  logic             go_idle_s;
  logic             inc_s;

  // Owner status, picker mask and round-robin start index.
  always_comb begin
    own_req_s = |(request & grant_r);
    others_s  = |(request & ~grant_r);
    // Excluding the owner only matters on a preemption; when the owner
    // keeps its grant the picker result is ignored.
    if ((state_r == ST_BUSY) && own_req_s) begin
      mask_s = ~grant_r;
    end else begin
      mask_s = {N_REQ{1'b1}};
    end
    if (rr_last_r == LAST_IDX) begin
      rr_start_s = {ID_W{1'b0}};
    end else begin
      rr_start_s = rr_last_r + ID_W'(1'b1);
    end
  end

  arb_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req    (request),
    .mask   (mask_s),
    .start  (rr_start_s),
    .mode   (arb_mode_e'(mode)),
    .winner (win_s),
    .found  (found_s)
  );

  assign win_id_s = ID_W'(onehot_to_idx(ARB_MAX_REQ'(win_s)));

  // FSM decision: new grant, release to idle, or keep and count.
  always_comb begin
    take_s    = 1'b0;
    go_idle_s = 1'b0;
    inc_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (found_s) begin
          take_s = 1'b1;
        end else begin
          take_s = 1'b0;
        end
      end
      ST_BUSY: begin
        if (!own_req_s) begin
          // Owner dropped: hand over on the same edge, or go idle.
          if (found_s) begin
            take_s = 1'b1;
          end else begin
            go_idle_s = 1'b1;
          end
        end else if ((hold_cnt_r == HOLD_LIM) && others_s) begin
          take_s = 1'b1;
        end else if (hold_cnt_r != HOLD_LIM) begin
          inc_s = 1'b1;
        end else begin
          // Sole requester at the limit keeps the grant, counter saturated.
          inc_s = 1'b0;
        end
      end
      default: begin
        go_idle_s = 1'b1;
      end
    endcase
  end

  // Next-state values derived from the decision.
  always_comb begin
    state_n_s    = state_r;
    grant_n_s    = grant_r;
    grant_id_n_s = grant_id_r;
    hold_cnt_n_s = hold_cnt_r;
    rr_last_n_s  = rr_last_r;
    if (take_s) begin
      state_n_s    = ST_BUSY;
      grant_n_s    = win_s;
      grant_id_n_s = win_id_s;
      hold_cnt_n_s = {CNT_W{1'b0}};
      rr_last_n_s  = win_id_s;
    end else if (go_idle_s) begin
      state_n_s    = ST_IDLE;
      grant_n_s    = {N_REQ{1'b0}};
      grant_id_n_s = {ID_W{1'b0}};
      hold_cnt_n_s = {CNT_W{1'b0}};
    end else if (inc_s) begin
      hold_cnt_n_s = hold_cnt_r + CNT_W'(1'b1);
    end else begin
      hold_cnt_n_s = hold_cnt_r;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      grant_r       <= {N_REQ{1'b0}};
      grant_valid_r <= 1'b0;
      grant_id_r    <= {ID_W{1'b0}};
      hold_cnt_r    <= {CNT_W{1'b0}};
      rr_last_r     <= LAST_IDX;
    end else begin
      state_r       <= state_n_s;
      grant_r       <= grant_n_s;
      grant_valid_r <= |grant_n_s;
      grant_id_r    <= grant_id_n_s;
      hold_cnt_r    <= hold_cnt_n_s;
      rr_last_r     <= rr_last_n_s;
    end
  end

  assign grant       = grant_r;
  assign grant_valid = grant_valid_r;
  assign grant_id    = grant_id_r;

  arb_rr_param_chk #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_chk (
    .clk         (clk),
    .rst         (rst),
    .request     (request),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

endmodule

// File: tb/tb_arb_rr_param.sv
// -----------------------------------------------------------------------------
// tb_arb_rr_param
// Scoreboard bench for arb_rr_param (N_REQ=4, MAX_HOLD=4). A behavioural
// model predicts the grant for each driven cycle; predictions are queued and
// compared one cycle later when the registered grant appears.
// -----------------------------------------------------------------------------
module tb_arb_rr_param;

  localparam int N  = 4;
  localparam int MH = 4;

  logic         clk;
  logic         rst;
  logic         mode;
  logic [N-1:0] request;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic [1:0]   grant_id;

  int n_tests;
  int n_fail;

  // Model state
  int m_owner;
  int m_hold;
  int m_last;

  logic [N-1:0] exp_q[$];
  logic [N-1:0] last_exp;

  arb_rr_param #(.N_REQ(N), .MAX_HOLD(MH)) dut (
    .clk         (clk),
    .rst         (rst),
    .mode        (mode),
    .request     (request),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick_m(input logic [N-1:0] r, input int excl, input logic fixed, input int last);
    int i;
    for (int o = 1; o <= N; o++) begin
      i = fixed ? (o - 1) : ((last + o) % N);
      if (r[i] && (i != excl)) return i;
    end
    return -1;
  endfunction

  function automatic logic [1:0] idx_of(input logic [N-1:0] oh);
    for (int i = 0; i < N; i++) if (oh[i]) return 2'(i);
    return 2'd0;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_hold  = 0;
    m_last  = N - 1;
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic md);
    int w;
    logic [N-1:0] others;
    if (m_owner < 0) begin
      w = pick_m(r, -1, md, m_last);
      if (w >= 0) begin m_owner = w; m_hold = 0; m_last = w; end
    end else if (!r[m_owner]) begin
      w = pick_m(r, -1, md, m_last);
      if (w >= 0) begin m_owner = w; m_last = w; end
      else m_owner = -1;
      m_hold = 0;
    end else begin
      others = r & ~(4'b0001 << m_owner);
      if ((m_hold == MH - 1) && (others != 4'b0000)) begin
        w = pick_m(r, m_owner, md, m_last);
        m_owner = w; m_hold = 0; m_last = w;
      end else if (m_hold < MH - 1) begin
        m_hold++;
      end
    end
  endtask

  // Drive inputs now (away from the edge), predict, then compare after the edge.
  task automatic step(input logic [N-1:0] r, input logic md);
    logic [N-1:0] e;
    request = r;
    mode    = md;
    model_step(r, md);
    exp_q.push_back((m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    last_exp = e;
    chk("grant", 32'(grant), 32'(e));
    chk("grant_valid", 32'(grant_valid), 32'(|e));
    chk("grant_id", 32'(grant_id), 32'(idx_of(e)));
  endtask

  initial begin
    logic [N-1:0] rr_pat;
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    mode    = 1'b0;
    request = 4'b0000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_valid", 32'(grant_valid), 32'h0);
    chk("rst_id", 32'(grant_id), 32'h0);

    // Basic handover with no idle bubble, then release.
    rst = 1'b0;
    step(4'b0101, 1'b0);
    chk("first_rr", 32'(grant), 32'h1);
    step(4'b0100, 1'b0);
    chk("handover", 32'(grant), 32'h4);
    step(4'b0000, 1'b0);
    chk("release_valid", 32'(grant_valid), 32'h0);

    // Park rr_last at 3 so the round-robin sweep starts at 0.
    step(4'b1000, 1'b0);
    step(4'b0000, 1'b0);
    for (int c = 0; c < 17; c++) begin
      step(4'b1111, 1'b0);
      rr_pat = 4'b0001 << ((c / MH) % N);
      chk("rr_sweep", 32'(grant), 32'(rr_pat));
    end

    // Fixed priority with all requesting: 0 and 1 alternate, 3 never wins.
    step(4'b0000, 1'b0);
    for (int c = 0; c < 12; c++) begin
      step(4'b1111, 1'b1);
      chk("fixed_alt", 32'(grant), (((c / MH) % 2) == 0) ? 32'h1 : 32'h2);
      chk("fixed_no3", 32'(grant[3]), 32'h0);
    end

    // Sole requester keeps the grant past MAX_HOLD.
    step(4'b0000, 1'b0);
    for (int c = 0; c < 10; c++) begin
      step(4'b0010, 1'b0);
      chk("sole_hold", 32'(grant), 32'h2);
    end
    chk("hold_sat", 32'(dut.hold_cnt_r), 32'(MH - 1));

    // Asynchronous reset while requester 2 owns the grant.
    step(4'b0100, 1'b0);
    chk("pre_rst", 32'(grant), 32'h4);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_grant", 32'(grant), 32'h0);
    chk("async_rst_valid", 32'(grant_valid), 32'h0);
    @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
    step(4'b1111, 1'b0);
    chk("post_rst_rr", 32'(grant), 32'h1);

    // Mode switch while owner 2 holds: no preemption until the hold limit,
    // then fixed priority picks 0 (round-robin would have picked 3).
    step(4'b0000, 1'b0);
    step(4'b0100, 1'b0);
    chk("owner2", 32'(grant), 32'h4);
    for (int k = 0; k < MH; k++) begin
      step(4'b1101, 1'b1);
      chk("mode_switch", 32'(grant), (k < MH - 1) ? 32'h4 : 32'h1);
    end

    // Random traffic against the model.
    for (int c = 0; c < 80; c++) begin
      step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
